// File: rtl/pattern_generator.sv
// Target-pattern source for the switch-copy game: an LFSR-fed pattern held until
// matched or expired, ROUNDS patterns per game, then a game-over hold.
module pattern_generator #(
   parameter int unsigned HOLD_TICKS = 50,
   parameter int unsigned ROUNDS     = 16,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic       counter10h,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] user_input,
   output logic [7:0] pattern,
   output logic [7:0] round,
   output logic       hit,
   output logic       timeout,
   output logic       game_over
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      DONE = 2'd2
   } state_t;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_INIT  = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] HOLD_LAST  = 16'(HOLD_TICKS - 1);
   localparam logic [7:0]  ROUND_LAST = 8'(ROUNDS);

   state_t      state;
   state_t      state_next;
   logic [15:0] lfsr;
   logic [15:0] lfsr_next;
   logic [15:0] hold_cnt;
   logic [15:0] hold_cnt_next;
   logic [7:0]  pattern_next;
   logic [7:0]  round_next;
   logic        hit_next;
   logic        timeout_next;
   logic        game_over_next;

   logic [7:0]  alt_pattern;
   logic [7:0]  fresh_pattern;
   logic        match;
   logic        expired;
   logic        last_round;
   logic        advance;

   // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
   assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

   assign match      = (user_input == pattern);
   assign expired    = (hold_cnt == HOLD_LAST);
   assign last_round = (round == ROUND_LAST);
   assign advance    = match || expired;

   // A fresh pattern is never zero and never repeats the one it replaces,
   // so the scorer always sees a change.
   always_comb begin
      alt_pattern = pattern + 8'd1;
      if (alt_pattern == 8'h00) begin
         alt_pattern = 8'h01;
      end
      if ((lfsr[7:0] == 8'h00) || (lfsr[7:0] == pattern)) begin
         fresh_pattern = alt_pattern;
      end else begin
         fresh_pattern = lfsr[7:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, whatever the statement order.
   always_ff @(posedge counter10h or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SHOW;
            end
         end
         SHOW: begin
            if (advance && last_round) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_next = SHOW;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      pattern_next   = pattern;
      round_next     = round;
      hold_cnt_next  = hold_cnt;
      hit_next       = 1'b0;
      timeout_next   = 1'b0;
      game_over_next = (state_next == DONE);
      case (state)
         IDLE, DONE: begin
            if (start) begin
               pattern_next  = fresh_pattern;
               round_next    = 8'd1;
               hold_cnt_next = 16'd0;
            end
         end
         SHOW: begin
            // A match outranks expiry, so a match on the last tick is a hit.
            if (match) begin
               hit_next = 1'b1;
            end else if (expired) begin
               timeout_next = 1'b1;
            end else begin
               hold_cnt_next = hold_cnt + 16'd1;
            end
            if (advance && !last_round) begin
               round_next    = round + 8'd1;
               pattern_next  = fresh_pattern;
               hold_cnt_next = 16'd0;
            end
         end
         default: begin
            pattern_next  = 8'h00;
            round_next    = 8'd0;
            hold_cnt_next = 16'd0;
         end
      endcase
   end

   always_ff @(posedge counter10h or negedge reset) begin
      if (!reset) begin
         lfsr      <= SEED_INIT;
         hold_cnt  <= 16'd0;
         pattern   <= 8'h00;
         round     <= 8'd0;
         hit       <= 1'b0;
         timeout   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         lfsr      <= lfsr_next;
         hold_cnt  <= hold_cnt_next;
         pattern   <= pattern_next;
         round     <= round_next;
         hit       <= hit_next;
         timeout   <= timeout_next;
         game_over <= game_over_next;
      end
   end

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: directed vector table, reset sequences and a
// randomized run checked against a game-level reference model.
module tb_pattern_generator;

   localparam int HOLD   = 4;
   localparam int NROUND = 3;

   logic       counter10h;
   logic       reset;
   logic       start;
   logic [7:0] user_input;
   logic [7:0] pattern;
   logic [7:0] round;
   logic       hit;
   logic       timeout;
   logic       game_over;

   int total = 0;
   int bad   = 0;

   pattern_generator #(
      .HOLD_TICKS(HOLD),
      .ROUNDS    (NROUND),
      .SEED      (16'hACE1)
   ) dut (
      .counter10h(counter10h),
      .reset     (reset),
      .start     (start),
      .user_input(user_input),
      .pattern   (pattern),
      .round     (round),
      .hit       (hit),
      .timeout   (timeout),
      .game_over (game_over)
   );

   initial counter10h = 1'b0;
   always #5 counter10h = ~counter10h;

   // Reference model: the game as a sequence of shown patterns.
   logic [15:0] m_lfsr;
   logic [7:0]  m_pat;
   logic [7:0]  m_round;
   int          m_shown;
   int          m_mode;   // 0 waiting for first game, 1 playing, 2 game over
   bit          m_hit;
   bit          m_to;

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
      logic fb;
      fb = v[0] ^ v[2] ^ v[3] ^ v[5];
      return {fb, v[15:1]};
   endfunction

   function automatic logic [7:0] pick(input logic [7:0] cand, input logic [7:0] prev);
      logic [7:0] alt;
      if (cand != 8'h00 && cand != prev) return cand;
      alt = prev + 8'd1;
      return (alt == 8'h00) ? 8'h01 : alt;
   endfunction

   task automatic model_reset();
      m_lfsr  = 16'hACE1;
      m_pat   = 8'h00;
      m_round = 8'd0;
      m_shown = 0;
      m_mode  = 0;
      m_hit   = 1'b0;
      m_to    = 1'b0;
   endtask

   task automatic model_step(input bit st, input logic [7:0] ui);
      logic [7:0] cand;
      cand  = m_lfsr[7:0];
      m_hit = 1'b0;
      m_to  = 1'b0;
      if (m_mode == 1) begin
         m_shown++;
         if (ui == m_pat) m_hit = 1'b1;
         else if (m_shown == HOLD) m_to = 1'b1;
         if (m_hit || m_to) begin
            if (int'(m_round) == NROUND) begin
               m_mode = 2;
            end else begin
               m_round = m_round + 8'd1;
               m_pat   = pick(cand, m_pat);
               m_shown = 0;
            end
         end
      end else if (st) begin
         m_pat   = pick(cand, m_pat);
         m_round = 8'd1;
         m_shown = 0;
         m_mode  = 1;
      end
      m_lfsr = lfsr_adv(m_lfsr);
   endtask

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic check_model();
      check("pattern", pattern, m_pat);
      check("round", round, m_round);
      check("hit", hit, m_hit);
      check("timeout", timeout, m_to);
      check("game_over", game_over, m_mode == 2);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_pattern"}, pattern, 0);
      check({tag, "_round"}, round, 0);
      check({tag, "_hit"}, hit, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_game_over"}, game_over, 0);
   endtask

   task automatic apply(input bit st, input logic [7:0] ui, input bit cmp_all);
      start      = st;
      user_input = ui;
      @(posedge counter10h);
      model_step(st, ui);
      #1;
      if (cmp_all) check_model();
   endtask

   typedef struct {
      bit         st;
      bit         mt;
      logic [7:0] rnd;
      bit         hit;
      bit         to;
      bit         go;
   } vec_t;

   vec_t vecs[19];

   initial begin
      logic [7:0] ui;
      logic [7:0] prev;
      bit         st;
      int         rounds;
      int         cycles;

      vecs = '{
         '{0, 0, 8'd0, 0, 0, 0},   // idle, no start
         '{0, 0, 8'd0, 0, 0, 0},
         '{0, 0, 8'd0, 0, 0, 0},
         '{1, 0, 8'd1, 0, 0, 0},   // start: first pattern
         '{1, 0, 8'd1, 0, 0, 0},   // start ignored while showing
         '{0, 0, 8'd1, 0, 0, 0},
         '{0, 0, 8'd1, 0, 0, 0},
         '{0, 0, 8'd2, 0, 1, 0},   // 4th edge unmatched: timeout
         '{0, 0, 8'd2, 0, 0, 0},
         '{0, 1, 8'd3, 1, 0, 0},   // match on 2nd tick
         '{0, 0, 8'd3, 0, 0, 0},
         '{0, 0, 8'd3, 0, 0, 0},
         '{0, 0, 8'd3, 0, 0, 0},
         '{0, 1, 8'd3, 1, 0, 1},   // match on expiry tick, last round
         '{0, 0, 8'd3, 0, 0, 1},   // game over holds
         '{1, 0, 8'd1, 0, 0, 0},   // restart from game over
         '{0, 1, 8'd2, 1, 0, 0},
         '{0, 1, 8'd3, 1, 0, 0},
         '{0, 1, 8'd3, 1, 0, 1}
      };

      reset      = 1'b0;
      start      = 1'b0;
      user_input = 8'h00;
      model_reset();
      @(posedge counter10h);
      #1;
      check_zero("reset");
      reset = 1'b1;

      for (int i = 0; i < 19; i++) begin
         ui = vecs[i].mt ? m_pat : ~m_pat;
         apply(vecs[i].st, ui, 1'b0);
         check($sformatf("vec%0d_pattern", i), pattern, m_pat);
         check($sformatf("vec%0d_round", i), round, vecs[i].rnd);
         check($sformatf("vec%0d_hit", i), hit, vecs[i].hit);
         check($sformatf("vec%0d_timeout", i), timeout, vecs[i].to);
         check($sformatf("vec%0d_game_over", i), game_over, vecs[i].go);
      end

      // Mid-tick reset while hit and game_over are both high.
      #3 reset = 1'b0;
      #1 check_zero("async_reset_done");
      @(posedge counter10h);
      #1 reset = 1'b1;
      model_reset();
      apply(1'b1, 8'hFF, 1'b1);
      check("seed_first_pattern", pattern, 8'hE1);

      rounds = 0;
      cycles = 0;
      while (rounds < 2000 && cycles < 40000) begin
         prev = pattern;
         st   = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0) ui = m_pat;
         else ui = 8'($urandom);
         apply(st, ui, 1'b1);
         cycles++;
         if (hit || timeout) begin
            rounds++;
            if (!game_over) begin
               check("new_pattern_distinct", (pattern != prev) && (pattern != 8'h00), 1'b1);
            end
         end
      end
      check("round_budget", rounds >= 2000, 1'b1);

      for (int k = 0; k < 12 && !(m_mode == 1 && m_shown >= 1 && m_shown <= HOLD - 2); k++) begin
         apply(1'b1, ~m_pat, 1'b1);
      end
      check("reach_mid_hold", (m_mode == 1 && m_shown >= 1 && m_shown <= HOLD - 2), 1'b1);

      #3 reset = 1'b0;
      #1 check_zero("async_reset_show");
      @(posedge counter10h);
      #1 reset = 1'b1;
      model_reset();
      apply(1'b1, 8'hFF, 1'b1);
      check("seed_repeat_pattern", pattern, 8'hE1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pattern_generator.md
Name: pattern_generator

Overview:
- Produces the target switch pattern that the player must copy, and drives the `pattern` input of score_calculator.
- Runs on the same 10 Hz tick clock as the scorer. Pattern values come from a free-running 16-bit LFSR.
- Each pattern is held until the player matches it or HOLD_TICKS ticks pass, whichever comes first. A game is ROUNDS patterns long, then the block holds in a game-over state.

Parameters:
- HOLD_TICKS, 50, maximum ticks a pattern is shown (5 s at 10 Hz). Legal range 2..65535.
- ROUNDS, 16, patterns per game. Legal range 1..255.
- SEED, 16'hACE1, LFSR reset value. The value 0 is replaced by 16'h0001.

Ports:
- counter10h  input  1  tick clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begins a game; sampled in IDLE and DONE only.
- user_input  input  8  player switch state; the same signal the scorer sees.
- pattern  output  8  current target pattern, registered.
- round  output  8  current round number, 1..ROUNDS; 0 in IDLE.
- hit  output  1  one-tick pulse when the player matched the pattern.
- timeout  output  1  one-tick pulse when a pattern expired unmatched.
- game_over  output  1  high while in DONE.

Behaviour:
- Reset (reset low, asynchronous), all outputs registered:
  - state=IDLE, pattern=0, round=0, hit=0, timeout=0, game_over=0.
  - hold_cnt=0, lfsr=SEED.
  - Release is synchronous to the next counter10h edge.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts on every edge in every state, so start timing randomises the sequence.
  - Never reaches 0.
- Next-pattern rule:
  - Candidate = lfsr[7:0] (pre-shift value at the edge).
  - If the candidate is 0 or equals the current pattern, use alt = pattern+1 instead; if alt wraps to 0, use 8'h01.
  - Result: a new pattern is always nonzero and always differs from the previous one. The scorer detects every change.
- IDLE:
  - pattern=0.
  - start=1 at an edge: load next pattern, round=1, hold_cnt=0, go to SHOW. Latency is 1 edge.
- SHOW, evaluated at each edge in priority order:
  1. user_input==pattern: hit=1 for this tick, then advance.
  2. Else if hold_cnt==HOLD_TICKS-1: timeout=1 for this tick, then advance.
  3. Else hold_cnt+=1.
  - start is ignored in SHOW.
- Advance:
  - If round==ROUNDS: go to DONE. The last pattern is held unchanged and game_over=1.
  - Else: round+=1, load next pattern, hold_cnt=0.
- Timing relative to the scorer:
  - The new pattern appears on the same edge at which the match is credited. The scorer sees the match on that edge using pre-edge values, so credit is preserved.
  - A pattern is visible for exactly HOLD_TICKS edges when unmatched.
- Simultaneous events: a match on the expiry tick counts as hit only; timeout stays 0.
- hit and timeout are each exactly 1 tick wide and are never both 1.
- DONE:
  - game_over=1; pattern, round and LFSR state are held, except that the LFSR keeps shifting.
  - start=1: round=1, new pattern, hold_cnt=0, game_over=0, go to SHOW.
- Reset mid-game: immediate return to reset values regardless of state. There are no partial pulses; hit and timeout clear asynchronously.
- Widths:
  - hold_cnt is 16 bits.
  - round is 8 bits and never exceeds ROUNDS.
  - No arithmetic overflow is possible within the legal parameter ranges.

Test Plan:
1. Reset values: assert reset low mid-tick -> all outputs 0 immediately. Release, apply 3 edges with start=0 -> pattern stays 0 and round stays 0.
2. Start: with SEED default, start=1 for one edge -> next edge gives pattern!=0, round=1. A later start pulse during SHOW -> no effect.
3. Timeout: HOLD_TICKS=4, user_input held at ~pattern -> pattern unchanged for exactly 4 edges. timeout=1 on the 4th edge, round=2, new pattern differs from the old one.
4. Hit: drive user_input=pattern on the 2nd tick -> hit=1 for one tick, round advances, pattern changes. With a match on the expiry tick -> hit=1, timeout=0.
5. Game end: ROUNDS=3, match each pattern -> after the 3rd hit, game_over=1, pattern holds, round=3. start=1 -> round=1, game_over=0.
6. Uniqueness and reset: run 2000 rounds with random matches and timeouts -> no pattern equals 0 and no two consecutive patterns are equal. Drop reset in SHOW mid-hold -> IDLE values, and after release the first pattern is reproducible from SEED.
